// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg : shared state encoding and constants for the program loader
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COUNT   = 3'd1,
        WORD_HI = 3'd2,
        WORD_LO = 3'd3,
        WRITE   = 3'd4,
        CSUM    = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/loader_word_assembler.sv
// ----------------------------------------------------------------------------
// loader_word_assembler : HI/LO byte latches and XOR checksum (LOADER_CHECKSUM_EN)
// Revision              : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module loader_word_assembler #(
    parameter int ADDR_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_data,
    input  logic                  hi_en,
    input  logic                  lo_en,
`ifdef LOADER_CHECKSUM_EN
    input  logic                  sum_clear,
    input  logic                  sum_en,
    output logic [7:0]            checksum,
`endif
    output logic [DATA_WIDTH-1:0] program_cmd
);

    logic [INSTRUCTION_WIDTH-1:0] hi_q;
    logic [ADDR_WIDTH-1:0]        lo_q;

    // Only the bits that form the word are kept; the rest of each byte is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_en) begin
                hi_q <= byte_data[INSTRUCTION_WIDTH-1:0];
            end
            if (lo_en) begin
                lo_q <= byte_data[ADDR_WIDTH-1:0];
            end
        end
    end

    assign program_cmd = {hi_q, lo_q};

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum <= 8'd0;
        end else if (sum_clear) begin
            checksum <= 8'd0;
        end else if (sum_en) begin
            checksum <= checksum ^ byte_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader : framed byte-stream loader for the instruction memory;
//                  CSUM byte checked only when LOADER_CHECKSUM_EN is defined
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_WIDTH        = 8,
    parameter int         INSTRUCTION_WIDTH = 4,
    parameter int         DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
    parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  program_write,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic                  cpu_hold_n,
    output logic                  load_done,
    output logic                  load_error
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t FINAL_STATE = CSUM;
`else
    localparam loader_state_t FINAL_STATE = DONE;
`endif

    loader_state_t state;
    loader_state_t next_state;
    logic [7:0]    word_count;
    logic          accept;
    logic          start;
    logic          hi_en;
    logic          lo_en;

    assign byte_ready = (state != WRITE);
    assign accept     = byte_valid && byte_ready;
    // A sync byte restarts only between frames; inside a frame it is data.
    assign start      = accept && (byte_data == SYNC_BYTE) &&
                        ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign hi_en      = accept && (state == WORD_HI);
    assign lo_en      = accept && (state == WORD_LO);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
    logic       sum_en;

    assign sum_en = accept && ((state == COUNT) || (state == WORD_HI) || (state == WORD_LO));
`endif

    loader_word_assembler #(
        .ADDR_WIDTH        (ADDR_WIDTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .DATA_WIDTH        (DATA_WIDTH)
    ) u_assembler (
        .clk         (clk),
        .reset       (reset),
        .byte_data   (byte_data),
        .hi_en       (hi_en),
        .lo_en       (lo_en),
`ifdef LOADER_CHECKSUM_EN
        .sum_clear   (start),
        .sum_en      (sum_en),
        .checksum    (checksum),
`endif
        .program_cmd (program_cmd)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    next_state = COUNT;
                end
            end
            COUNT: begin
                if (accept) begin
                    next_state = (byte_data == 8'd0) ? FINAL_STATE : WORD_HI;
                end
            end
            WORD_HI: begin
                if (accept) begin
                    next_state = WORD_LO;
                end
            end
            WORD_LO: begin
                if (accept) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = (word_count == 8'd1) ? FINAL_STATE : WORD_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    next_state = (byte_data == checksum) ? DONE : ERROR;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            word_count    <= 8'd0;
            prog_addr     <= '0;
            program_write <= 1'b0;
            cpu_hold_n    <= 1'b1;
            load_done     <= 1'b0;
        end else begin
            state         <= next_state;
            program_write <= (next_state == WRITE);
            if (start) begin
                cpu_hold_n <= 1'b0;
                load_done  <= 1'b0;
                prog_addr  <= '0;
            end
            if ((state == COUNT) && accept) begin
                word_count <= byte_data;
            end
            if (state == WRITE) begin
                prog_addr  <= prog_addr + ADDR_WIDTH'(1);
                word_count <= word_count - 8'd1;
            end
            if ((next_state == DONE) && (state != DONE)) begin
                cpu_hold_n <= 1'b1;
                load_done  <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_error <= 1'b0;
        end else if (start) begin
            load_error <= 1'b0;
        end else if ((next_state == ERROR) && (state != ERROR)) begin
            load_error <= 1'b1;
        end
    end
`else
    assign load_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader : directed self-checking bench for program_loader
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        program_write;
    logic [11:0] program_cmd;
    logic [7:0]  prog_addr;
    logic        cpu_hold_n;
    logic        load_done;
    logic        load_error;

    int checks;
    int failures;

    logic [11:0] wr_cmd  [0:63];
    logic [7:0]  wr_addr [0:63];
    int          wr_cnt;
    int          ready_viol;
    logic        mon_en;

    program_loader dut (
        .clk           (clk),
        .reset         (reset),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .program_write (program_write),
        .program_cmd   (program_cmd),
        .prog_addr     (prog_addr),
        .cpu_hold_n    (cpu_hold_n),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write and flag any cycle where byte_ready is not the inverse of the strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            if (program_write === 1'b1) begin
                if (wr_cnt < 64) begin
                    wr_cmd[wr_cnt]  = program_cmd;
                    wr_addr[wr_cnt] = prog_addr;
                end
                wr_cnt = wr_cnt + 1;
            end
            if (byte_ready !== ~program_write) begin
                ready_viol = ready_viol + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   tries;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        tries      = 0;
        forever begin
            rdy = byte_ready;
            tick();
            if (rdy === 1'b1) break;
            tries++;
            if (tries > 20) begin
                checks++;
                failures++;
                $display("FAIL send_timeout byte=%02h byte_ready never high", b);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic finish_frame(input logic [7:0] csum, input int gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, gap);
`else
        if (csum !== 8'hxx) tick();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({byte_ready, program_write, program_cmd, prog_addr, cpu_hold_n, load_done, load_error}
                !== {1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got rdy=%b wr=%b cmd=%03h addr=%02h hold=%b done=%b err=%b",
                     byte_ready, program_write, program_cmd, prog_addr, cpu_hold_n, load_done, load_error);
        end
        reset  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Reset asserted while waiting for a LO byte.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        checks++;
        if (cpu_hold_n !== 1'b0) begin
            failures++;
            $display("FAIL hold_during_load got %b want 0", cpu_hold_n);
        end
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({byte_ready, program_write, program_cmd, prog_addr, cpu_hold_n, load_done, load_error}
                !== {1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midframe_reset got rdy=%b wr=%b cmd=%03h addr=%02h hold=%b done=%b err=%b",
                     byte_ready, program_write, program_cmd, prog_addr, cpu_hold_n, load_done, load_error);
        end
        reset = 1'b1;
        send_byte(8'h23, 0);
        tick();
        checks++;
        if ({wr_cnt, cpu_hold_n, load_done} !== {32'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL after_reset_idle got writes=%0d hold=%b done=%b want 0 1 0",
                     wr_cnt, cpu_hold_n, load_done);
        end
    endtask

    // Frame 02: words {1,23} and {F,FF}; checksum 02^01^23^0F^FF = D0.
    task automatic std_frame(input int gap, input string tag);
        int base;
        base = wr_cnt;
        send_byte(8'hA5, gap);
        checks++;
        if ({cpu_hold_n, load_done} !== 2'b00) begin
            failures++;
            $display("FAIL %s_start got hold=%b done=%b want 0 0", tag, cpu_hold_n, load_done);
        end
        send_byte(8'h02, gap);
        send_byte(8'h01, gap);
        send_byte(8'h23, gap);
        checks++;
        if ({program_write, byte_ready, program_cmd, prog_addr} !== {1'b1, 1'b0, 12'h123, 8'h00}) begin
            failures++;
            $display("FAIL %s_write_latency got wr=%b rdy=%b cmd=%03h addr=%02h want 1 0 123 00",
                     tag, program_write, byte_ready, program_cmd, prog_addr);
        end
        send_byte(8'h0F, gap);
        send_byte(8'hFF, gap);
        finish_frame(8'hD0, gap);
        checks++;
        if ({wr_cnt - base, wr_cmd[base], wr_addr[base], wr_cmd[base+1], wr_addr[base+1]}
                !== {32'd2, 12'h123, 8'h00, 12'hFFF, 8'h01}) begin
            failures++;
            $display("FAIL %s_writes got n=%0d %03h@%02h %03h@%02h want 2 123@00 FFF@01", tag,
                     wr_cnt - base, wr_cmd[base], wr_addr[base], wr_cmd[base+1], wr_addr[base+1]);
        end
        checks++;
        if ({load_done, cpu_hold_n, load_error, prog_addr} !== {1'b1, 1'b1, 1'b0, 8'h02}) begin
            failures++;
            $display("FAIL %s_done got done=%b hold=%b err=%b addr=%02h want 1 1 0 02",
                     tag, load_done, cpu_hold_n, load_error, prog_addr);
        end
    endtask

    task automatic test_frame();
        std_frame(0, "frame");
    endtask

    task automatic test_stall();
        int viol0;
        viol0 = ready_viol;
        std_frame(1, "stall");
        checks++;
        if (ready_viol !== viol0) begin
            failures++;
            $display("FAIL stall_ready_vs_write got %0d violations want 0", ready_viol - viol0);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_error();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h23, 0);
        send_byte(8'h0F, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h00, 0);
        checks++;
        if ({load_error, cpu_hold_n, load_done} !== 3'b100) begin
            failures++;
            $display("FAIL bad_csum got err=%b hold=%b done=%b want 1 0 0", load_error, cpu_hold_n, load_done);
        end
        send_byte(8'h11, 0);
        checks++;
        if ({load_error, cpu_hold_n} !== 2'b10) begin
            failures++;
            $display("FAIL error_discard got err=%b hold=%b want 1 0", load_error, cpu_hold_n);
        end
        std_frame(0, "recover");
    endtask
`endif

    task automatic test_empty();
        int base;
        base = wr_cnt;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        checks++;
        if ({wr_cnt - base, load_done, cpu_hold_n} !== {32'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL discard_bytes got writes=%0d done=%b hold=%b want 0 1 1",
                     wr_cnt - base, load_done, cpu_hold_n);
        end
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        finish_frame(8'h00, 0);
        tick();
        checks++;
        if ({wr_cnt - base, load_done, cpu_hold_n, load_error, prog_addr}
                !== {32'd0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL empty_frame got writes=%0d done=%b hold=%b err=%b addr=%02h want 0 1 1 0 00",
                     wr_cnt - base, load_done, cpu_hold_n, load_error, prog_addr);
        end
    endtask

    // A5 as LO byte is data: checksum 01^03^A5 = A7.
    task automatic test_sync_data();
        int base;
        base = wr_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h03, 0);
        send_byte(8'hA5, 0);
        finish_frame(8'hA7, 0);
        checks++;
        if ({wr_cnt - base, wr_cmd[base], wr_addr[base], load_done} !== {32'd1, 12'h3A5, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL sync_as_data got n=%0d %03h@%02h done=%b want 1 3A5@00 1",
                     wr_cnt - base, wr_cmd[base], wr_addr[base], load_done);
        end
    endtask

    // Single word 344; checksum 01^03^44 = 46 when the CSUM byte exists.
    task automatic test_single_word();
        int base;
        base = wr_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h03, 0);
        send_byte(8'h44, 0);
        finish_frame(8'h46, 0);
        checks++;
        if ({wr_cnt - base, wr_cmd[base], wr_addr[base], load_done, cpu_hold_n}
                !== {32'd1, 12'h344, 8'h00, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL single_word got n=%0d %03h@%02h done=%b hold=%b want 1 344@00 1 1",
                     wr_cnt - base, wr_cmd[base], wr_addr[base], load_done, cpu_hold_n);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        wr_cnt     = 0;
        ready_viol = 0;
        mon_en     = 1'b0;
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        tick();
        test_reset();
        test_frame();
`ifdef LOADER_CHECKSUM_EN
        test_error();
`endif
        test_empty();
        test_stall();
        test_sync_data();
        test_single_word();
        checks++;
        if (ready_viol !== 0) begin
            failures++;
            $display("FAIL ready_vs_write got %0d violations want 0", ready_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
